// File: rtl/iomem_pkg.sv
// iomem_pkg: shared types and constants for the PicoSoC iomem router.
//   state_e          - router FSM states
//   PAGE_W           - width of the page field m_addr[31:24]
//   SLOT_LSB/SLOT_W  - position and width of the slot field m_addr[19:16]
//   ERR_DATA_DEFAULT - read word returned on decode error or timeout
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int PAGE_W   = 8;
    localparam int SLOT_LSB = 16;
    localparam int SLOT_W   = 4;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_wdt.sv
// iomem_wdt: bus watchdog counter for the iomem router.
//   clk      - system clock
//   resetn   - asynchronous active-low reset
//   clr_i    - synchronous clear of the count (dominates en_i)
//   en_i     - count one cycle while high
//   expire_o - high while the count equals TIMEOUT-1
module iomem_wdt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [7:0] count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 8'd0;
        end else if (clr_i) begin
            count_q <= 8'd0;
        end else if (en_i && !expire_o) begin
            // Stops at the terminal value; the router leaves WAIT on expiry.
            count_q <= count_q + 8'd1;
        end
    end

    assign expire_o = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/iomem_router.sv
// iomem_router: decodes the PicoSoC iomem page into NSLAVES peripheral slots,
// runs the valid/ready handshake to the selected slot, returns read data and
// terminates hung or undecoded accesses with ERR_DATA plus an error pulse.
//   clk, resetn        - clock, asynchronous active-low reset
//   m_valid/m_ready    - master request / one-cycle completion pulse
//   m_wstrb/m_addr/m_wdata/m_rdata - master access and returned read word
//   s_valid/s_ready    - one-hot slot request / per-slot completion
//   s_wstrb/s_addr/s_wdata - latched access, broadcast to every slot
//   s_rdata            - flattened slot read data, slot i at [32*i+31:32*i]
//   err_count          - saturating count of decode errors plus timeouts
//   err_irq            - one-cycle pulse per error
module iomem_router
    import iomem_pkg::*;
#(
    parameter int          NSLAVES  = 4,
    parameter logic [7:0]  PAGE     = 8'h03,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic [3:0]              m_wstrb,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    output logic [31:0]             m_rdata,
    output logic [NSLAVES-1:0]      s_valid,
    input  logic [NSLAVES-1:0]      s_ready,
    output logic [3:0]              s_wstrb,
    output logic [15:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic [32*NSLAVES-1:0]   s_rdata,
    output logic [7:0]              err_count,
    output logic                    err_irq
);

    localparam logic [SLOT_W:0] NSLOTS_L = (SLOT_W + 1)'(NSLAVES);

    state_e               state_q;
    logic                 m_ready_q;
    logic [31:0]          m_rdata_q;
    logic [NSLAVES-1:0]   s_valid_q;
    logic [3:0]           s_wstrb_q;
    logic [15:0]          s_addr_q;
    logic [31:0]          s_wdata_q;
    logic [SLOT_W-1:0]    slot_q;
    logic [7:0]           err_count_q;
    logic [7:0]           err_count_d;
    logic                 err_irq_q;

    logic [SLOT_W-1:0]    req_slot;
    logic                 req_slot_ok;
    logic                 accept;
    logic [NSLAVES-1:0]   req_onehot;
    logic [31:0]          rdata_arr [NSLAVES];
    logic                 sel_ready;
    logic [31:0]          sel_rdata;
    logic                 expire;

    // Address bits between the page and slot fields are don't-care.
    logic                 unused_addr;
    assign unused_addr = ^m_addr[23:20];

    assign req_slot    = m_addr[SLOT_LSB +: SLOT_W];
    assign req_slot_ok = ({1'b0, req_slot} < NSLOTS_L);
    assign accept      = m_valid && !m_ready_q &&
                         (m_addr[31 -: PAGE_W] == PAGE);

    genvar gi;
    generate
        for (gi = 0; gi < NSLAVES; gi++) begin : g_slot
            assign req_onehot[gi] = (req_slot == SLOT_W'(gi));
            assign rdata_arr[gi]  = s_rdata[32*gi +: 32];
        end
    endgenerate

    // Only the latched slot's ready/data are looked at; others are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'd0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = rdata_arr[i];
            end
        end
    end

    assign err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

    // Timer is held at zero outside WAIT so each access starts from 0.
    iomem_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk      (clk),
        .resetn   (resetn),
        .clr_i    (state_q != WAIT),
        .en_i     (state_q == WAIT),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            m_ready_q   <= 1'b0;
            m_rdata_q   <= 32'd0;
            s_valid_q   <= '0;
            s_wstrb_q   <= 4'd0;
            s_addr_q    <= 16'd0;
            s_wdata_q   <= 32'd0;
            slot_q      <= '0;
            err_count_q <= 8'd0;
            err_irq_q   <= 1'b0;
        end else begin
            m_ready_q <= 1'b0;
            err_irq_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        s_wstrb_q <= m_wstrb;
                        s_addr_q  <= m_addr[15:0];
                        s_wdata_q <= m_wdata;
                        slot_q    <= req_slot;
                        if (req_slot_ok) begin
                            s_valid_q <= req_onehot;
                            state_q   <= WAIT;
                        end else begin
                            m_rdata_q   <= ERR_DATA;
                            m_ready_q   <= 1'b1;
                            err_irq_q   <= 1'b1;
                            err_count_q <= err_count_d;
                            state_q     <= RESP;
                        end
                    end
                end
                WAIT: begin
                    // Ready beats a simultaneous timeout; an aborted request
                    // is dropped silently.
                    if (sel_ready) begin
                        s_valid_q <= '0;
                        m_rdata_q <= sel_rdata;
                        m_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end else if (!m_valid) begin
                        s_valid_q <= '0;
                        state_q   <= IDLE;
                    end else if (expire) begin
                        s_valid_q   <= '0;
                        m_rdata_q   <= ERR_DATA;
                        m_ready_q   <= 1'b1;
                        err_irq_q   <= 1'b1;
                        err_count_q <= err_count_d;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    s_valid_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign m_ready   = m_ready_q;
    assign m_rdata   = m_rdata_q;
    assign s_valid   = s_valid_q;
    assign s_wstrb   = s_wstrb_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign err_count = err_count_q;
    assign err_irq   = err_irq_q;

endmodule

// File: tb/tb_iomem_router.sv
// tb_iomem_router: directed self-checking bench for iomem_router
// (NSLAVES=4, PAGE=8'h03, TIMEOUT=16, ERR_DATA=32'hDEAD_BEEF).
module tb_iomem_router;

    logic         clk;
    logic         resetn;
    logic         m_valid;
    logic         m_ready;
    logic [3:0]   m_wstrb;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [3:0]   s_wstrb;
    logic [15:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [7:0]   err_count;
    logic         err_irq;

    int errors = 0;
    int checks = 0;

    iomem_router #(
        .NSLAVES  (4),
        .PAGE     (8'h03),
        .TIMEOUT  (16),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_wstrb   (m_wstrb),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_wstrb   (s_wstrb),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .err_count (err_count),
        .err_irq   (err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
        m_valid = 1'b1;
        m_addr  = addr;
        m_wstrb = strb;
        m_wdata = data;
    endtask

    task automatic release_master();
        m_valid = 1'b0;
        m_wstrb = 4'd0;
    endtask

    initial begin
        int  sv_cycles;
        logic seen;
        int  budget;

        resetn  = 1'b0;
        m_valid = 1'b0;
        m_wstrb = 4'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        s_ready = 4'd0;
        s_rdata = {32'hCAFE_0003, 32'h5555_0002, 32'h1234_5678, 32'h0000_1111};

        // ---- reset state ----
        step(); step();
        check("rst_m_ready",   {31'd0, m_ready},   32'd0);
        check("rst_s_valid",   {28'd0, s_valid},   32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_m_rdata",   m_rdata,            32'd0);
        check("rst_err_irq",   {31'd0, err_irq},   32'd0);
        check("rst_s_addr",    {16'd0, s_addr},    32'd0);
        resetn = 1'b1;
        step();

        // ---- read slot 1, ready 3 cycles after s_valid ----
        issue(32'h0301_0004, 4'd0, 32'd0);
        step();                                   // cycle 1
        check("rd1_s_valid", {28'd0, s_valid}, 32'h2);
        check("rd1_s_addr",  {16'd0, s_addr},  32'h0004);
        check("rd1_m_ready_c1", {31'd0, m_ready}, 32'd0);
        s_ready = 4'b0100;                        // unselected slot, ignored
        step();                                   // cycle 2
        s_ready = 4'b0000;
        step();                                   // cycle 3
        check("rd1_unsel_ignored", {31'd0, m_ready}, 32'd0);
        check("rd1_s_valid_c3", {28'd0, s_valid}, 32'h2);
        step();                                   // cycle 4
        s_ready = 4'b0010;
        step();                                   // cycle 5
        s_ready = 4'b0000;
        check("rd1_m_ready", {31'd0, m_ready}, 32'd1);
        check("rd1_m_rdata", m_rdata, 32'h1234_5678);
        check("rd1_s_valid_drop", {28'd0, s_valid}, 32'd0);
        check("rd1_err_irq", {31'd0, err_irq}, 32'd0);
        release_master();
        step();
        check("rd1_m_ready_pulse", {31'd0, m_ready}, 32'd0);
        check("rd1_m_rdata_hold", m_rdata, 32'h1234_5678);
        check("rd1_err_count", {24'd0, err_count}, 32'd0);
        $display("read slot1 addr=03010004 rdata=%08h", m_rdata);

        // ---- write slot 0, immediate ready ----
        issue(32'h0300_0000, 4'b0011, 32'hAABB_CCDD);
        s_ready = 4'b0001;
        step();                                   // cycle 1
        check("wr0_s_wstrb", {28'd0, s_wstrb}, 32'h3);
        check("wr0_s_wdata", s_wdata, 32'hAABB_CCDD);
        check("wr0_s_valid", {28'd0, s_valid}, 32'h1);
        check("wr0_m_ready_c1", {31'd0, m_ready}, 32'd0);
        step();                                   // cycle 2
        s_ready = 4'b0000;
        check("wr0_m_ready_c2", {31'd0, m_ready}, 32'd1);
        check("wr0_m_rdata", m_rdata, 32'h0000_1111);
        release_master();
        step();
        $display("write slot0 addr=03000000 wstrb=3 wdata=AABBCCDD");

        // ---- slot 2 never ready: timeout ----
        issue(32'h0302_0010, 4'd0, 32'd0);
        sv_cycles = 0;
        for (int i = 0; i < 16; i++) begin        // cycles 1..16
            step();
            if (s_valid == 4'b0100 && !m_ready) sv_cycles++;
        end
        check("to_s_valid_cycles", sv_cycles, 32'd16);
        step();                                   // cycle 17
        check("to_s_valid_drop", {28'd0, s_valid}, 32'd0);
        check("to_m_ready", {31'd0, m_ready}, 32'd1);
        check("to_m_rdata", m_rdata, 32'hDEAD_BEEF);
        check("to_err_irq", {31'd0, err_irq}, 32'd1);
        check("to_err_count", {24'd0, err_count}, 32'd1);
        release_master();
        step();
        check("to_err_irq_pulse", {31'd0, err_irq}, 32'd0);
        $display("timeout slot2 rdata=%08h err_count=%0d", m_rdata, err_count);

        // ---- decode error: slot 7 >= NSLAVES ----
        issue(32'h0307_0000, 4'd0, 32'd0);
        step();
        check("dec_m_ready", {31'd0, m_ready}, 32'd1);
        check("dec_m_rdata", m_rdata, 32'hDEAD_BEEF);
        check("dec_s_valid", {28'd0, s_valid}, 32'd0);
        check("dec_err_irq", {31'd0, err_irq}, 32'd1);
        check("dec_err_count", {24'd0, err_count}, 32'd2);
        release_master();
        step();
        check("dec_m_ready_pulse", {31'd0, m_ready}, 32'd0);
        $display("decode error addr=03070000 err_count=%0d", err_count);

        // ---- foreign page: no response ----
        issue(32'h0200_0000, 4'd0, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_ready || s_valid != 4'd0 || err_irq) seen = 1'b1;
        end
        check("page_no_response", {31'd0, seen}, 32'd0);
        check("page_err_count", {24'd0, err_count}, 32'd2);
        release_master();
        step();
        $display("foreign page addr=02000000 ignored");

        // ---- master abort mid-WAIT ----
        issue(32'h0301_0000, 4'd0, 32'd0);
        step();
        check("abort_s_valid", {28'd0, s_valid}, 32'h2);
        release_master();
        step();
        check("abort_s_valid_drop", {28'd0, s_valid}, 32'd0);
        check("abort_m_ready", {31'd0, m_ready}, 32'd0);
        check("abort_err_count", {24'd0, err_count}, 32'd2);
        step();
        $display("abort slot1 err_count=%0d", err_count);

        // ---- reset mid-WAIT ----
        issue(32'h0301_0008, 4'd0, 32'd0);
        step(); step();
        check("mrst_s_valid_before", {28'd0, s_valid}, 32'h2);
        resetn = 1'b0;
        #1;
        check("mrst_s_valid", {28'd0, s_valid}, 32'd0);
        check("mrst_m_ready", {31'd0, m_ready}, 32'd0);
        check("mrst_err_count", {24'd0, err_count}, 32'd0);
        release_master();
        step();
        resetn = 1'b1;
        step();
        issue(32'h0303_0020, 4'd0, 32'd0);
        s_ready = 4'b1000;
        step();
        check("s3_s_valid", {28'd0, s_valid}, 32'h8);
        check("s3_s_addr", {16'd0, s_addr}, 32'h0020);
        step();
        s_ready = 4'b0000;
        check("s3_m_ready", {31'd0, m_ready}, 32'd1);
        check("s3_m_rdata", m_rdata, 32'hCAFE_0003);
        release_master();
        step();
        $display("reset mid-wait, then read slot3 rdata=%08h", m_rdata);

        // ---- 300 back-to-back timeouts: saturation ----
        for (int n = 0; n < 300; n++) begin
            issue(32'h0302_0000, 4'd0, 32'd0);
            budget = 0;
            step();
            while (!m_ready && budget < 40) begin
                step();
                budget++;
            end
            if (!m_ready) begin
                check("sat_wait_m_ready", {31'd0, m_ready}, 32'd1);
            end else begin
                check("sat_err_irq", {31'd0, err_irq}, 32'd1);
                check("sat_rdata", m_rdata, 32'hDEAD_BEEF);
            end
            if (n == 253) check("sat_count_254", {24'd0, err_count}, 32'd254);
            $display("timeout %0d err_count=%0d", n + 1, err_count);
            release_master();
            step();
        end
        check("sat_err_count", {24'd0, err_count}, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
